// File: rtl/sbox_bist_if.sv
// sbox_bist_if: connects the S-box BIST engine to its controller and the S-box under test.
//   start           controller -> BIST  request a run
//   busy/done/pass  BIST -> controller  run status; pass is valid while done is high
//   err_count       BIST -> controller  saturating count of mismatching bytes
//   first_err_*     BIST -> controller  capture of the earliest mismatch (byte, mode, DUT output)
//   test_valid      BIST -> DUT side    high on issue cycles
//   test_encrypt    BIST -> DUT side    mode for the DUT encrypt inputs
//   test_bytes      BIST -> DUT side    lane k in bits [8k+7:8k]
//   dut_bytes       DUT side -> BIST    DUT outputs, lane-aligned with test_bytes
interface sbox_bist_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ERR_W = 10
);
  logic               start;
  logic               busy;
  logic               done;
  logic               pass;
  logic [ERR_W-1:0]   err_count;
  logic               first_err_valid;
  logic [7:0]         first_err_byte;
  logic               first_err_mode;
  logic [7:0]         first_err_got;
  logic               test_valid;
  logic               test_encrypt;
  logic [8*LANES-1:0] test_bytes;
  logic [8*LANES-1:0] dut_bytes;

  // Controller / harness side.
  modport master (
    output start,
    output dut_bytes,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_err_valid,
    input  first_err_byte,
    input  first_err_mode,
    input  first_err_got,
    input  test_valid,
    input  test_encrypt,
    input  test_bytes
  );

  // BIST engine side.
  modport slave (
    input  start,
    input  dut_bytes,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_err_valid,
    output first_err_byte,
    output first_err_mode,
    output first_err_got,
    output test_valid,
    output test_encrypt,
    output test_bytes
  );
endinterface

// File: rtl/sbox_bist.sv
// sbox_bist: built-in self-test for an AES S-box implementation.
// Sweeps all 256 inputs in encrypt mode, then in decrypt mode, LANES bytes per cycle, and
// compares the DUT outputs against golden S-box copies delayed by DUT_LATENCY cycles.
// Reports pass/fail, a saturating mismatch count and the first failing vector.
//   clk   rising-edge clock
//   rst   synchronous active-high reset; returns to idle, zeroes outputs, flushes the pipeline
//   bist  sbox_bist_if.slave: start/status/first-error outputs and the DUT stimulus/response
module sbox_bist #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned DUT_LATENCY = 0,
  parameter int unsigned ERR_W       = 10
) (
  input logic        clk,
  input logic        rst,
  sbox_bist_if.slave bist
);

  localparam int unsigned BW       = 8 * LANES;
  localparam int unsigned SumW     = ERR_W + 5;
  localparam int unsigned DrainW   = (DUT_LATENCY > 1) ? $clog2(DUT_LATENCY) : 1;
  localparam logic [7:0]  LaneStep = 8'(LANES);
  localparam logic [7:0]  LastBase = 8'(256 - LANES);
  localparam logic [ERR_W-1:0]  ErrMax    = '1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'((DUT_LATENCY == 0) ? 0 : DUT_LATENCY - 1);

  typedef enum logic [2:0] {StIdle, StEnc, StDec, StDrain, StDone} state_e;

  // ---------------------------------------------------------------------------------------------
  // Golden S-box arithmetic over GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1
  // ---------------------------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] r;
    y = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      y = gf_mul(y, y);
      r = gf_mul(r, y);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [BW-1:0] lane_bytes(input logic [7:0] base);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(LANES); k++) v[8*k +: 8] = base + 8'(k);
    return v;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------------------------
  state_e            state_q;
  logic [7:0]        base_q;
  logic [DrainW-1:0] drain_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ERR_W-1:0]  err_count_q;
  logic              first_valid_q;
  logic [7:0]        first_byte_q;
  logic              first_mode_q;
  logic [7:0]        first_got_q;
  logic              test_valid_q;
  logic              test_encrypt_q;
  logic [BW-1:0]     test_bytes_q;

  // Golden copies see exactly what the DUT sees.
  logic [BW-1:0] gold_bytes;
  always_comb begin
    gold_bytes = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      gold_bytes[8*k +: 8] = test_encrypt_q ? sbox_fwd(test_bytes_q[8*k +: 8])
                                            : sbox_inv(test_bytes_q[8*k +: 8]);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Delay line aligning golden/issued data with the DUT response
  // ---------------------------------------------------------------------------------------------
  logic          cmp_valid;
  logic          cmp_mode;
  logic [BW-1:0] cmp_exp;
  logic [BW-1:0] cmp_in;

  if (DUT_LATENCY == 0) begin : g_direct
    assign cmp_valid = test_valid_q;
    assign cmp_mode  = test_encrypt_q;
    assign cmp_exp   = gold_bytes;
    assign cmp_in    = test_bytes_q;
  end else begin : g_pipe
    logic [DUT_LATENCY-1:0] vld_q;
    logic [DUT_LATENCY-1:0] mode_q;
    logic [BW-1:0]          exp_q [DUT_LATENCY];
    logic [BW-1:0]          in_q  [DUT_LATENCY];

    // Reset clears the valid bits so no stale compare survives a mid-run reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= '0;
        mode_q <= '0;
        for (int i = 0; i < int'(DUT_LATENCY); i++) begin
          exp_q[i] <= '0;
          in_q[i]  <= '0;
        end
      end else begin
        vld_q[0]  <= test_valid_q;
        mode_q[0] <= test_encrypt_q;
        exp_q[0]  <= gold_bytes;
        in_q[0]   <= test_bytes_q;
        for (int i = 1; i < int'(DUT_LATENCY); i++) begin
          vld_q[i]  <= vld_q[i-1];
          mode_q[i] <= mode_q[i-1];
          exp_q[i]  <= exp_q[i-1];
          in_q[i]   <= in_q[i-1];
        end
      end
    end

    assign cmp_valid = vld_q[DUT_LATENCY-1];
    assign cmp_mode  = mode_q[DUT_LATENCY-1];
    assign cmp_exp   = exp_q[DUT_LATENCY-1];
    assign cmp_in    = in_q[DUT_LATENCY-1];
  end

  // ---------------------------------------------------------------------------------------------
  // Compare: per-lane mismatches, saturating count, lowest-lane first error
  // ---------------------------------------------------------------------------------------------
  logic [LANES-1:0] mismatch;
  logic [SumW-1:0]  popcnt;
  logic [SumW-1:0]  err_sum;
  logic [ERR_W-1:0] err_next;
  logic             lane_found;
  logic [7:0]       lane_byte;
  logic [7:0]       lane_got;

  always_comb begin
    mismatch   = '0;
    popcnt     = '0;
    lane_found = 1'b0;
    lane_byte  = '0;
    lane_got   = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      mismatch[k] = cmp_valid && (bist.dut_bytes[8*k +: 8] != cmp_exp[8*k +: 8]);
      popcnt      = popcnt + SumW'(mismatch[k]);
      if (mismatch[k] && !lane_found) begin
        lane_found = 1'b1;
        lane_byte  = cmp_in[8*k +: 8];
        lane_got   = bist.dut_bytes[8*k +: 8];
      end
    end
    err_sum  = SumW'(err_count_q) + popcnt;
    err_next = (err_sum > SumW'(ErrMax)) ? ErrMax : err_sum[ERR_W-1:0];
  end

  // ---------------------------------------------------------------------------------------------
  // Sweep FSM with registered outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      base_q         <= '0;
      drain_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      err_count_q    <= '0;
      first_valid_q  <= 1'b0;
      first_byte_q   <= '0;
      first_mode_q   <= 1'b0;
      first_got_q    <= '0;
      test_valid_q   <= 1'b0;
      test_encrypt_q <= 1'b0;
      test_bytes_q   <= '0;
    end else begin
      // err_next equals err_count_q when nothing is compared, so this is safe every cycle.
      err_count_q <= err_next;
      if (lane_found && !first_valid_q) begin
        first_valid_q <= 1'b1;
        first_byte_q  <= lane_byte;
        first_mode_q  <= cmp_mode;
        first_got_q   <= lane_got;
      end

      unique case (state_q)
        StIdle, StDone: begin
          if (bist.start) begin
            state_q        <= StEnc;
            base_q         <= '0;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            err_count_q    <= '0;
            first_valid_q  <= 1'b0;
            first_byte_q   <= '0;
            first_mode_q   <= 1'b0;
            first_got_q    <= '0;
            test_valid_q   <= 1'b1;
            test_encrypt_q <= 1'b1;
            test_bytes_q   <= lane_bytes(8'h00);
          end
        end

        StEnc: begin
          if (base_q == LastBase) begin
            state_q        <= StDec;
            base_q         <= '0;
            test_encrypt_q <= 1'b0;
            test_bytes_q   <= lane_bytes(8'h00);
          end else begin
            base_q       <= base_q + LaneStep;
            test_bytes_q <= lane_bytes(base_q + LaneStep);
          end
        end

        StDec: begin
          if (base_q == LastBase) begin
            base_q       <= '0;
            test_valid_q <= 1'b0;
            test_bytes_q <= '0;
            if (DUT_LATENCY > 0) begin
              state_q <= StDrain;
              drain_q <= '0;
            end else begin
              // The last compare lands on this edge, so pass uses the updated count.
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_next == '0);
            end
          end else begin
            base_q       <= base_q + LaneStep;
            test_bytes_q <= lane_bytes(base_q + LaneStep);
          end
        end

        StDrain: begin
          if (drain_q == DrainLast) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_next == '0);
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bist.busy            = busy_q;
  assign bist.done            = done_q;
  assign bist.pass            = pass_q;
  assign bist.err_count       = err_count_q;
  assign bist.first_err_valid = first_valid_q;
  assign bist.first_err_byte  = first_byte_q;
  assign bist.first_err_mode  = first_mode_q;
  assign bist.first_err_got   = first_got_q;
  assign bist.test_valid      = test_valid_q;
  assign bist.test_encrypt    = test_encrypt_q;
  assign bist.test_bytes      = test_bytes_q;

endmodule

// File: tb/tb_sbox_bist.sv
// Bench for sbox_bist: two instances (4 lanes / combinational DUT, 8 lanes / 2-stage DUT with a
// 4-bit error counter), an S-box model built from log/antilog tables, a per-cycle reference
// model of the sweep, and directed runs with literal expectations.
module tb_sbox_bist;

  localparam int unsigned LA = 4;
  localparam int unsigned TA = 0;
  localparam int unsigned EA = 10;
  localparam int unsigned LB = 8;
  localparam int unsigned TB = 2;
  localparam int unsigned EB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sbox_bist_if #(.LANES(LA), .ERR_W(EA)) bus_a ();
  sbox_bist_if #(.LANES(LB), .ERR_W(EB)) bus_b ();

  sbox_bist #(.LANES(LA), .DUT_LATENCY(TA), .ERR_W(EA)) u_a (
    .clk  (clk),
    .rst  (rst),
    .bist (bus_a)
  );

  sbox_bist #(.LANES(LB), .DUT_LATENCY(TB), .ERR_W(EB)) u_b (
    .clk  (clk),
    .rst  (rst),
    .bist (bus_b)
  );

  int n_chk = 0;
  int n_ok  = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- S-box model from exp/log tables (generator 3) ----------------
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  task automatic build_tables();
    logic [7:0] exp_t [256];
    int         log_t [256];
    logic [7:0] p, v, s, cst;
    p   = 8'h01;
    cst = 8'h63;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = p;
      log_t[p] = i;
      p = p ^ ({p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00));
    end
    for (int x = 0; x < 256; x++) begin
      v = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
      for (int b = 0; b < 8; b++) begin
        s[b] = v[b] ^ v[(b + 4) % 8] ^ v[(b + 5) % 8] ^ v[(b + 6) % 8] ^ v[(b + 7) % 8] ^ cst[b];
      end
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [7:0] gold(input logic [7:0] x, input logic enc);
    return enc ? fwd_t[x] : inv_t[x];
  endfunction

  // ---------------- S-boxes under test, with selectable faults ----------------
  // fa: 0 clean, 1 enc 0x53 -> 0x00, 2 one register stage. fb: 0 clean, 1 inverted output.
  int fa = 0;
  int fb = 0;
  logic [8*LA-1:0] comb_a, reg_a;
  logic [8*LB-1:0] comb_b, p1_b, p2_b;

  always_comb begin
    comb_a = '0;
    for (int k = 0; k < int'(LA); k++) begin
      comb_a[8*k +: 8] = gold(bus_a.test_bytes[8*k +: 8], bus_a.test_encrypt);
      if (fa == 1 && bus_a.test_encrypt && bus_a.test_bytes[8*k +: 8] == 8'h53)
        comb_a[8*k +: 8] = 8'h00;
    end
  end

  always_comb begin
    comb_b = '0;
    for (int k = 0; k < int'(LB); k++) begin
      comb_b[8*k +: 8] = gold(bus_b.test_bytes[8*k +: 8], bus_b.test_encrypt);
      if (fb == 1) comb_b[8*k +: 8] = ~comb_b[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    reg_a <= comb_a;
    p1_b  <= comb_b;
    p2_b  <= p1_b;
  end

  assign bus_a.dut_bytes = (fa == 2) ? reg_a : comb_a;
  assign bus_b.dut_bytes = p2_b;

  logic [63:0] act_a, act_b;
  assign act_a = {25'd0, bus_a.busy, bus_a.done, bus_a.pass, bus_a.test_valid, bus_a.test_encrypt,
                  bus_a.first_err_valid, bus_a.first_err_mode, bus_a.first_err_byte,
                  bus_a.first_err_got, 16'(bus_a.err_count)};
  assign act_b = {25'd0, bus_b.busy, bus_b.done, bus_b.pass, bus_b.test_valid, bus_b.test_encrypt,
                  bus_b.first_err_valid, bus_b.first_err_mode, bus_b.first_err_byte,
                  bus_b.first_err_got, 16'(bus_b.err_count)};

  // ---------------- Reference model: run position -> expected outputs ----------------
  bit         m_run [2];
  int         m_c   [2];
  int         m_err [2];
  bit         m_done[2], m_pass[2], m_enc[2], m_fv[2], m_fm[2];
  logic [7:0] m_fb  [2], m_fg[2];

  // Busy cycle c (1-based) issues encrypt bases for the first 256/lanes cycles, then decrypt.
  function automatic void issue_at(input int lanes, input int c, output bit v, output bit mode,
                                   output logic [127:0] bytes);
    int n, idx;
    n     = 256 / lanes;
    idx   = c - 1;
    v     = (idx >= 0) && (idx < 2 * n);
    mode  = (idx < n);
    bytes = '0;
    if (v) begin
      for (int k = 0; k < lanes; k++) bytes[8*k +: 8] = 8'(((mode ? idx : idx - n) * lanes) + k);
    end
  endfunction

  task automatic model_step(input int id, input int lanes, input int lat, input int errmax,
                            input logic [63:0] act_st, input logic [127:0] act_tb,
                            input logic [127:0] dut_in, input logic st, input logic rs);
    bit iv, im, cv, cm, e_valid, e_enc;
    logic [127:0] ib, cb;
    logic [7:0] g;
    int n;
    string nm;
    nm = (id == 0) ? "a" : "b";
    n  = 256 / lanes;
    iv = 1'b0;
    im = 1'b0;
    ib = '0;
    if (m_run[id]) issue_at(lanes, m_c[id], iv, im, ib);
    e_valid = m_run[id] && iv;
    e_enc   = e_valid ? im : m_enc[id];
    chk({nm, ".cycle_status"}, act_st,
        {25'd0, m_run[id], m_done[id], m_pass[id], e_valid, e_enc, m_fv[id], m_fm[id], m_fb[id],
         m_fg[id], 16'(m_err[id])});
    chk({nm, ".cycle_test_bytes"}, act_tb, e_valid ? ib : 128'd0);

    if (rs) begin
      m_run[id] = 0; m_c[id] = 0; m_err[id] = 0; m_done[id] = 0; m_pass[id] = 0;
      m_enc[id] = 0; m_fv[id] = 0; m_fm[id] = 0; m_fb[id] = '0; m_fg[id] = '0;
    end else begin
      m_enc[id] = e_enc;
      if (m_run[id]) begin
        issue_at(lanes, m_c[id] - lat, cv, cm, cb);
        if (cv) begin
          for (int k = 0; k < lanes; k++) begin
            g = gold(cb[8*k +: 8], cm);
            if (dut_in[8*k +: 8] !== g) begin
              if (m_err[id] < errmax) m_err[id]++;
              if (!m_fv[id]) begin
                m_fv[id] = 1; m_fb[id] = cb[8*k +: 8]; m_fm[id] = cm; m_fg[id] = dut_in[8*k +: 8];
              end
            end
          end
        end
        if (m_c[id] == 2 * n + lat) begin
          m_run[id] = 0; m_done[id] = 1; m_pass[id] = (m_err[id] == 0);
        end else begin
          m_c[id]++;
        end
      end else if (st) begin
        m_run[id] = 1; m_c[id] = 1; m_err[id] = 0; m_done[id] = 0; m_pass[id] = 0;
        m_fv[id] = 0; m_fm[id] = 0; m_fb[id] = '0; m_fg[id] = '0;
      end
    end
  endtask

  // Single compare process: check both instances every cycle, mid-cycle.
  always @(negedge clk) begin
    model_step(0, LA, TA, (1 << EA) - 1, act_a, 128'(bus_a.test_bytes), 128'(bus_a.dut_bytes),
               bus_a.start, rst);
    model_step(1, LB, TB, (1 << EB) - 1, act_b, 128'(bus_b.test_bytes), 128'(bus_b.dut_bytes),
               bus_b.start, rst);
  end

  // ---------------- Directed stimulus ----------------
  task automatic pulse_start(input bit a, input bit b);
    @(posedge clk); #1;
    bus_a.start = a;
    bus_b.start = b;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_idle(input int which, output int cnt);
    cnt = 0;
    while (((which == 0) ? bus_a.busy : bus_b.busy) && cnt < 1000) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("busy_timeout", (which == 0) ? bus_a.busy : bus_b.busy, 1'b0);
  endtask

  initial begin
    int cnt;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    build_tables();
    chk("rom.fwd_00", fwd_t[8'h00], 8'h63);
    chk("rom.fwd_01", fwd_t[8'h01], 8'h7c);
    chk("rom.fwd_53", fwd_t[8'h53], 8'hed);
    chk("rom.fwd_ff", fwd_t[8'hff], 8'h16);
    chk("rom.inv_00", inv_t[8'h00], 8'h52);
    chk("rom.inv_63", inv_t[8'h63], 8'h00);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("a.reset_state", {act_a, 128'(bus_a.test_bytes)}, '0);
    chk("b.reset_state", {act_b, 128'(bus_b.test_bytes)}, '0);

    // Clean run, 4 lanes, combinational DUT.
    pulse_start(1'b1, 1'b0);
    wait_idle(0, cnt);
    chk("a.clean_busy_len", cnt, 128);
    chk("a.clean_done", bus_a.done, 1'b1);
    chk("a.clean_pass", bus_a.pass, 1'b1);
    chk("a.clean_err", bus_a.err_count, 0);
    chk("a.clean_fev", bus_a.first_err_valid, 1'b0);

    // Single fault at 0x53 encrypt (lane 3 of base 0x50).
    fa = 1;
    pulse_start(1'b1, 1'b0);
    wait_idle(0, cnt);
    chk("a.fault_err", bus_a.err_count, 1);
    chk("a.fault_byte", bus_a.first_err_byte, 8'h53);
    chk("a.fault_mode", bus_a.first_err_mode, 1'b1);
    chk("a.fault_got", bus_a.first_err_got, 8'h00);
    chk("a.fault_pass", bus_a.pass, 1'b0);

    // Registered DUT against a zero-latency BIST.
    fa = 2;
    pulse_start(1'b1, 1'b0);
    wait_idle(0, cnt);
    chk("a.lat_pass", bus_a.pass, 1'b0);
    chk("a.lat_byte", bus_a.first_err_byte, 8'h00);
    chk("a.lat_mode", bus_a.first_err_mode, 1'b1);
    fa = 0;

    // Pipelined run, 8 lanes, latency 2.
    pulse_start(1'b0, 1'b1);
    wait_idle(1, cnt);
    chk("b.pipe_busy_len", cnt, 66);
    chk("b.pipe_pass", bus_b.pass, 1'b1);
    chk("b.pipe_done", bus_b.done, 1'b1);

    // Inverted output with a 4-bit counter saturates.
    fb = 1;
    pulse_start(1'b0, 1'b1);
    wait_idle(1, cnt);
    chk("b.sat_err", bus_b.err_count, 15);
    chk("b.sat_pass", bus_b.pass, 1'b0);
    chk("b.sat_got", bus_b.first_err_got, 8'h9c);

    // Reset at busy cycle 50 with both running; b keeps its faulty DUT to expose stale compares.
    pulse_start(1'b1, 1'b1);
    cnt = 1;
    while (cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("a.midrst_outputs", {act_a, 128'(bus_a.test_bytes)}, '0);
    chk("b.midrst_outputs", {act_b, 128'(bus_b.test_bytes)}, '0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b.no_stale_err", bus_b.err_count, 0);
    fb = 0;
    pulse_start(1'b1, 1'b0);
    wait_idle(0, cnt);
    chk("a.after_rst_len", cnt, 128);
    chk("a.after_rst_pass", bus_a.pass, 1'b1);

    // start while busy is ignored, including on the last busy cycle.
    pulse_start(1'b1, 1'b0);
    cnt = 0;
    while (bus_a.busy && cnt < 1000) begin
      cnt++;
      bus_a.start = (cnt == 20) || (cnt == 128);
      @(posedge clk); #1;
    end
    bus_a.start = 1'b0;
    chk("a.busy_start_len", cnt, 128);
    chk("a.busy_start_done", bus_a.done, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("a.busy_start_norestart", bus_a.busy, 1'b0);
    chk("a.busy_start_pass", bus_a.pass, 1'b1);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
